// File: rtl/vga_pattern_pkg.sv
// vga_pattern_pkg: mode encoding, mode count and bar colour table shared by the VGA pattern generator
package vga_pattern_pkg;

    typedef enum logic [1:0] {
        BARS    = 2'd0,
        CHECKER = 2'd1,
        HGRAD   = 2'd2,
        VGRAD   = 2'd3
    } mode_t;

    localparam int N_MODES = 4;

    // {r,g,b} full-scale flags, entry 0 in the LSBs:
    // black, red, yellow, green, cyan, blue, magenta, white
    localparam logic [23:0] BAR_TABLE = {
        3'b111, 3'b101, 3'b001, 3'b011,
        3'b010, 3'b110, 3'b100, 3'b000
    };

    function automatic logic [2:0] bar_rgb(input logic [2:0] idx);
        return BAR_TABLE[idx * 3 +: 3];
    endfunction

    function automatic mode_t next_mode(input mode_t m);
        return (m == VGRAD) ? BARS : mode_t'(m + 2'd1);
    endfunction

endpackage

// File: rtl/vga_pattern_mode_ctrl.sv
// vga_pattern_mode_ctrl: frame-start detect, pending step flag, mode FSM and (with PATTERN_SCROLL_EN) scroll offset
module vga_pattern_mode_ctrl
    import vga_pattern_pkg::*;
#(
    parameter int XW = 10,
    parameter int YW = 9
`ifdef PATTERN_SCROLL_EN
    ,
    parameter int H_ACTIVE    = 640,
    parameter int SCROLL_STEP = 4
`endif
) (
    input  logic          i_Clk,
    input  logic          rst_n,
    input  logic [XW-1:0] i_x_pos,
    input  logic [YW-1:0] i_y_pos,
    input  logic          i_valid,
    input  logic          i_mode_step,
    output mode_t         o_mode,
    output mode_t         o_mode_pix
`ifdef PATTERN_SCROLL_EN
    ,
    output logic [XW-1:0] o_offset_pix
`endif
);

    logic  w_frame_start;
    logic  w_adv;
    logic  r_pending;
    mode_t r_mode;

    assign w_frame_start = i_valid && (i_x_pos == '0) && (i_y_pos == '0);
    assign w_adv         = w_frame_start && (r_pending || i_mode_step);
    assign o_mode        = r_mode;
    // The frame-start pixel is already rendered in the mode the register is about to take.
    assign o_mode_pix    = w_adv ? next_mode(r_mode) : r_mode;

    // Mode FSM: collapse any number of step pulses into one advance at the next frame start
    always_ff @(posedge i_Clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mode    <= BARS;
            r_pending <= 1'b0;
        end else begin
            r_pending <= !w_adv && (r_pending || i_mode_step);
            if (w_adv)
                r_mode <= next_mode(r_mode);
        end
    end

`ifdef PATTERN_SCROLL_EN
    logic [XW-1:0] r_offset;
    logic [XW-1:0] w_offset_next;

    assign w_offset_next = (r_offset >= XW'(H_ACTIVE - SCROLL_STEP))
                         ? r_offset + XW'(SCROLL_STEP) - XW'(H_ACTIVE)
                         : r_offset + XW'(SCROLL_STEP);
    assign o_offset_pix  = w_frame_start ? w_offset_next : r_offset;

    // Scroll offset: advance once per frame start, wrapping modulo the active width
    always_ff @(posedge i_Clk or negedge rst_n) begin
        if (!rst_n)
            r_offset <= '0;
        else if (w_frame_start)
            r_offset <= w_offset_next;
    end
`endif

endmodule

// File: rtl/vga_pattern_gen.sv
// vga_pattern_gen: multi-mode VGA test pattern (bars/checker/h-ramp/v-ramp); PATTERN_SCROLL_EN enables horizontal scroll
module vga_pattern_gen
    import vga_pattern_pkg::*;
#(
    parameter int H_ACTIVE    = 640,
    parameter int V_ACTIVE    = 480,
    parameter int CW          = 3,
    parameter int N_BARS      = 8,
    parameter int CHK_LOG2    = 5,
    parameter int SCROLL_STEP = 4,
    localparam int XW = $clog2(H_ACTIVE),
    localparam int YW = $clog2(V_ACTIVE)
) (
    input  logic          i_Clk,
    input  logic          rst_n,
    input  logic [XW-1:0] i_x_pos,
    input  logic [YW-1:0] i_y_pos,
    input  logic          i_valid,
    input  logic          i_mode_step,
    output logic [CW-1:0] o_r,
    output logic [CW-1:0] o_g,
    output logic [CW-1:0] o_b,
    output logic          o_valid,
    output logic [1:0]    o_mode
);

    localparam int BAR_W  = H_ACTIVE / N_BARS;
    localparam int HSTEP  = H_ACTIVE >> CW;
    localparam int VSTEP  = V_ACTIVE >> CW;
    localparam int LEVELS = 1 << CW;

    if (N_BARS < 1 || N_BARS > 8 || SCROLL_STEP < 1 || SCROLL_STEP >= H_ACTIVE) begin : g_bad_param
        $error("vga_pattern_gen: unsupported parameter set");
    end

    mode_t           w_mode;
    mode_t           w_mode_pix;
    logic [XW-1:0]   w_x_eff;
    logic [2:0]      w_bar_idx;
    logic [2:0]      w_bar_rgb;
    logic [CW-1:0]   w_hg;
    logic [CW-1:0]   w_vg;
    logic            w_chk;
    logic [3*CW-1:0] w_rgb;
    logic [3*CW-1:0] r_rgb;
    logic            r_valid;

`ifdef PATTERN_SCROLL_EN
    logic [XW-1:0] w_offset;
    logic [XW:0]   w_x_sum;
`endif

    vga_pattern_mode_ctrl #(
        .XW(XW),
        .YW(YW)
`ifdef PATTERN_SCROLL_EN
        ,
        .H_ACTIVE(H_ACTIVE),
        .SCROLL_STEP(SCROLL_STEP)
`endif
    ) u_mode_ctrl (
        .i_Clk(i_Clk),
        .rst_n(rst_n),
        .i_x_pos(i_x_pos),
        .i_y_pos(i_y_pos),
        .i_valid(i_valid),
        .i_mode_step(i_mode_step),
        .o_mode(w_mode),
        .o_mode_pix(w_mode_pix)
`ifdef PATTERN_SCROLL_EN
        ,
        .o_offset_pix(w_offset)
`endif
    );

`ifdef PATTERN_SCROLL_EN
    // Both operands are below H_ACTIVE, so one conditional subtract is a full modulo.
    assign w_x_sum = {1'b0, i_x_pos} + {1'b0, w_offset};
    assign w_x_eff = (w_x_sum >= (XW+1)'(H_ACTIVE))
                   ? XW'(w_x_sum - (XW+1)'(H_ACTIVE))
                   : XW'(w_x_sum);
`else
    assign w_x_eff = i_x_pos;
`endif

    // Bar index and grey levels as counts of thresholds passed, avoiding any divider
    always_comb begin
        w_bar_idx = '0;
        w_hg      = '0;
        w_vg      = '0;
        for (int k = 1; k < N_BARS; k++)
            if (32'(w_x_eff) >= k * BAR_W)
                w_bar_idx = w_bar_idx + 3'd1;
        for (int k = 1; k < LEVELS; k++) begin
            if (32'(w_x_eff) >= k * HSTEP)
                w_hg = w_hg + CW'(1);
            if (32'(i_y_pos) >= k * VSTEP)
                w_vg = w_vg + CW'(1);
        end
    end

    assign w_bar_rgb = bar_rgb(w_bar_idx);
    assign w_chk     = w_x_eff[CHK_LOG2] ^ i_y_pos[CHK_LOG2];

    assign w_rgb = !i_valid                ? '0 :
                   (w_mode_pix == BARS)    ? {{CW{w_bar_rgb[2]}}, {CW{w_bar_rgb[1]}}, {CW{w_bar_rgb[0]}}} :
                   (w_mode_pix == CHECKER) ? {(3*CW){w_chk}} :
                   (w_mode_pix == HGRAD)   ? {3{w_hg}} :
                                             {3{w_vg}};

    // Output stage: one-cycle registered colour with matching valid
    always_ff @(posedge i_Clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rgb   <= '0;
            r_valid <= 1'b0;
        end else begin
            r_rgb   <= w_rgb;
            r_valid <= i_valid;
        end
    end

    assign o_r     = r_rgb[3*CW-1:2*CW];
    assign o_g     = r_rgb[2*CW-1:CW];
    assign o_b     = r_rgb[CW-1:0];
    assign o_valid = r_valid;
    assign o_mode  = w_mode;

endmodule
